// File: rtl/vga_sync_receiver.sv
// VGA timing monitor: locks to the displayer's hsync/vsync and recovers pixel coordinates, errors and a probe pixel.
// Latency: 3 pix_en cycles from an input sample to the matching counter/coordinate/probe outputs.
// Backpressure: none; pix_en qualifies every sample and all state holds while it is low.
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic        frame_start,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [7:0]  err_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_OFF  = H_SYNC + H_BP;
  localparam int VS_OFF  = V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_TMO  = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_LO   = 11'(HS_OFF);
  localparam logic [10:0] H_HI   = 11'(HS_OFF + H_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LO   = 10'(VS_OFF);
  localparam logic [9:0]  V_HI   = 10'(VS_OFF + V_ACTIVE);
  localparam logic        SYNC_OFF = ~SYNC_POL;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        viol;
  logic        hs_s1, hs_s2, hs_s3;
  logic        vs_s1, vs_s2, vs_s3;
  logic [11:0] rgb_s1, rgb_s2, rgb_s3;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  px_x_hold, px_y_hold;
  logic [9:0]  probe_x_q, probe_y_q;
  logic        hs_edge, vs_edge;
  logic        probe_hit;

  // Input pipeline; stage 3 is both the edge-detect history and the colour aligned with h_cnt/v_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_s1 <= SYNC_OFF; hs_s2 <= SYNC_OFF; hs_s3 <= SYNC_OFF;
      vs_s1 <= SYNC_OFF; vs_s2 <= SYNC_OFF; vs_s3 <= SYNC_OFF;
      rgb_s1 <= '0; rgb_s2 <= '0; rgb_s3 <= '0;
    end else if (pix_en) begin
      hs_s1 <= hsync;  hs_s2 <= hs_s1;  hs_s3 <= hs_s2;
      vs_s1 <= vsync;  vs_s2 <= vs_s1;  vs_s3 <= vs_s2;
      rgb_s1 <= {red, green, blue};
      rgb_s2 <= rgb_s1;
      rgb_s3 <= rgb_s2;
    end
  end

  assign hs_edge = (hs_s2 == SYNC_POL) && (hs_s3 != SYNC_POL);
  assign vs_edge = (vs_s2 == SYNC_POL) && (vs_s3 != SYNC_POL);

  // Pixel and line counters, restarted by sync assertion edges and saturating at full scale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (hs_edge)
        h_cnt <= '0;
      else if (h_cnt != 11'h7FF)
        h_cnt <= h_cnt + 11'd1;
      if (vs_edge)
        v_cnt <= '0;
      else if (hs_edge && v_cnt != 10'h3FF)
        v_cnt <= v_cnt + 10'd1;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  // Timing checks: vsync check wins over hsync check so a sample yields at most one violation.
  always_comb begin
    state_nxt = state;
    viol      = 1'b0;
    if (pix_en) begin
      if (state == SEARCH) begin
        if (vs_edge)
          state_nxt = MEASURE;
      end else begin
        if (vs_edge && v_cnt != V_LAST)
          viol = 1'b1;
        else if (hs_edge && h_cnt != H_LAST)
          viol = 1'b1;
        else if (!hs_edge && h_cnt >= H_TMO)
          viol = 1'b1;
        if (viol)
          state_nxt = SEARCH;
        else if (vs_edge)
          state_nxt = LOCKED;
      end
    end
  end

  assign locked    = (state == LOCKED);
  assign px_valid  = locked && (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
  assign px_x      = px_valid ? 10'(h_cnt - H_LO) : px_x_hold;
  assign px_y      = px_valid ? (v_cnt - V_LO) : px_y_hold;
  assign probe_hit = pix_en && px_valid && (px_x == probe_x_q) && (px_y == probe_y_q);

  // Frame pulse, per-frame probe snapshot, probe capture, coordinate hold and error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      probe_x_q   <= '0;
      probe_y_q   <= '0;
      probe_valid <= 1'b0;
      probe_rgb   <= '0;
      px_x_hold   <= '0;
      px_y_hold   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_start <= pix_en && vs_edge && (state_nxt == LOCKED);
      probe_valid <= probe_hit;
      if (pix_en && vs_edge && state_nxt == LOCKED) begin
        probe_x_q <= probe_x;
        probe_y_q <= probe_y;
      end
      if (probe_hit)
        probe_rgb <= rgb_s3;
      if (px_valid) begin
        px_x_hold <= px_x;
        px_y_hold <= px_y;
      end
      if (pix_en && viol && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
